// File: rtl/vga_timing_pkg.sv
// Shared timing constants and phase type for the 800x600@72Hz raster generator.
package vga_timing_pkg;

   localparam int VGA_H_ACTIVE = 800;
   localparam int VGA_H_FP     = 56;
   localparam int VGA_H_SYNC   = 120;
   localparam int VGA_H_BP     = 64;
   localparam int VGA_V_ACTIVE = 600;
   localparam int VGA_V_FP     = 37;
   localparam int VGA_V_SYNC   = 6;
   localparam int VGA_V_BP     = 23;

   localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   typedef enum logic [1:0] {
      PH_VIS  = 2'd0,
      PH_FP   = 2'd1,
      PH_SYNC = 2'd2,
      PH_BP   = 2'd3
   } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, VIS/FP/SYNC/BP phase tracker and registered sync.
// phase is the phase being entered on this edge, so downstream flops align with count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 800,
   parameter int FP     = 56,
   parameter int SYNC   = 120,
   parameter int BP     = 64,
   parameter int W      = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count,
   output phase_e       phase,
   output logic         wrap,
   output logic         sync
);

   localparam logic [W-1:0] LAST       = W'(ACTIVE + FP + SYNC + BP - 1);
   localparam logic [W-1:0] FP_START   = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
   localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);

   logic [W-1:0] count_d, count_q;
   phase_e       phase_d, phase_q;
   logic         sync_d, sync_q;

   // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      sync_d  = sync_q;
      wrap    = inc && (count_q == LAST);
      if (inc) begin
         count_d = wrap ? '0 : count_q + W'(1);
         if (count_d == FP_START)        phase_d = PH_FP;
         else if (count_d == SYNC_START) phase_d = PH_SYNC;
         else if (count_d == BP_START)   phase_d = PH_BP;
         else if (count_d == '0)         phase_d = PH_VIS;
         sync_d = (phase_d == PH_SYNC);
      end
   end

   // NOTE: non-blocking assignments, so every flop samples pre-edge values regardless of order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= LAST;
         phase_q <= PH_BP;
         sync_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
         sync_q  <= sync_d;
      end
   end

   assign count = count_q;
   assign phase = phase_d;
   assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, syncs, display enable and line/frame strobes.
// Reset parks at the last position so the first enabled edge lands on (0,0).
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE = VGA_H_ACTIVE,
   parameter int   H_FP     = VGA_H_FP,
   parameter int   H_SYNC   = VGA_H_SYNC,
   parameter int   H_BP     = VGA_H_BP,
   parameter int   V_ACTIVE = VGA_V_ACTIVE,
   parameter int   V_FP     = VGA_V_FP,
   parameter int   V_SYNC   = VGA_V_SYNC,
   parameter int   V_BP     = VGA_V_BP,
   parameter logic SYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic [10:0] h_count,
   output logic [9:0]  v_count,
   output logic        hsync,
   output logic        vsync,
   output logic        video_active,
   output logic        line_start,
   output logic        frame_start
);

   logic   h_wrap, v_wrap, h_sync, v_sync;
   phase_e h_phase, v_phase;
   logic   video_active_d, video_active_q;
   logic   line_start_d, line_start_q;
   logic   frame_start_d, frame_start_q;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
   ) u_h_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (en),
      .count (h_count),
      .phase (h_phase),
      .wrap  (h_wrap),
      .sync  (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
   ) u_v_axis (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (en & h_wrap),
      .count (v_count),
      .phase (v_phase),
      .wrap  (v_wrap),
      .sync  (v_sync)
   );

   // h_wrap already carries en, and v_wrap only fires on an h-wrap edge.
   always_comb begin
      video_active_d = video_active_q;
      if (en) video_active_d = (h_phase == PH_VIS) && (v_phase == PH_VIS);
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         video_active_q <= 1'b0;
         line_start_q   <= 1'b0;
         frame_start_q  <= 1'b0;
      end else begin
         video_active_q <= video_active_d;
         line_start_q   <= line_start_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign hsync        = h_sync ? SYNC_POL : ~SYNC_POL;
   assign vsync        = v_sync ? SYNC_POL : ~SYNC_POL;
   assign video_active = video_active_q;
   assign line_start   = line_start_q;
   assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size 800x600 instance plus a shrunken-geometry instance (negative syncs)
// so frame/vsync behaviour is reachable in a short run; both follow a position model.
module tb_vga_timing_gen;

   typedef struct {
      int   ha, hfp, hs, hbp;
      int   va, vfp, vs, vbp;
      logic pol;
   } geom_t;

   typedef struct {
      int   h, v;
      logic ls, fs;
   } model_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [10:0] h_cnt [2];
   logic [9:0]  v_cnt [2];
   logic [1:0]  hs_o, vs_o, va_o, ls_o, fs_o;

   geom_t  geo [2];
   model_t m   [2];
   int     n_assert = 0;
   int     n_fail   = 0;
   int     cyc      = 0;
   int     last_fs  = -1;
   logic   measure  = 1'b0;

   always #10 clk = ~clk;

   vga_timing_gen u_dut_big (
      .clk(clk), .rst_n(rst_n), .en(en),
      .h_count(h_cnt[0]), .v_count(v_cnt[0]),
      .hsync(hs_o[0]), .vsync(vs_o[0]), .video_active(va_o[0]),
      .line_start(ls_o[0]), .frame_start(fs_o[0])
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
      .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(3),
      .SYNC_POL(1'b0)
   ) u_dut_small (
      .clk(clk), .rst_n(rst_n), .en(en),
      .h_count(h_cnt[1]), .v_count(v_cnt[1]),
      .hsync(hs_o[1]), .vsync(vs_o[1]), .video_active(va_o[1]),
      .line_start(ls_o[1]), .frame_start(fs_o[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int h_total(input int i);
      return geo[i].ha + geo[i].hfp + geo[i].hs + geo[i].hbp;
   endfunction

   function automatic int v_total(input int i);
      return geo[i].va + geo[i].vfp + geo[i].vs + geo[i].vbp;
   endfunction

   task automatic model_reset(input int i);
      m[i].h  = h_total(i) - 1;
      m[i].v  = v_total(i) - 1;
      m[i].ls = 1'b0;
      m[i].fs = 1'b0;
   endtask

   task automatic model_step(input int i, input logic e);
      if (e) begin
         m[i].h = m[i].h + 1;
         if (m[i].h == h_total(i)) begin
            m[i].h = 0;
            m[i].v = (m[i].v + 1 == v_total(i)) ? 0 : m[i].v + 1;
         end
         m[i].ls = (m[i].h == 0);
         m[i].fs = (m[i].h == 0) && (m[i].v == 0);
      end else begin
         m[i].ls = 1'b0;
         m[i].fs = 1'b0;
      end
   endtask

   task automatic check_all(input int i, input string where);
      string u;
      int    hlo, vlo;
      logic  exp_hs, exp_vs, exp_va;
      u      = (i == 0) ? "big" : "small";
      hlo    = geo[i].ha + geo[i].hfp;
      vlo    = geo[i].va + geo[i].vfp;
      exp_hs = (m[i].h >= hlo && m[i].h < hlo + geo[i].hs) ? geo[i].pol : ~geo[i].pol;
      exp_vs = (m[i].v >= vlo && m[i].v < vlo + geo[i].vs) ? geo[i].pol : ~geo[i].pol;
      exp_va = (m[i].h < geo[i].ha) && (m[i].v < geo[i].va);
      check({where, "/", u, " h_count"},      32'(h_cnt[i]), m[i].h);
      check({where, "/", u, " v_count"},      32'(v_cnt[i]), m[i].v);
      check({where, "/", u, " hsync"},        32'(hs_o[i]),  32'(exp_hs));
      check({where, "/", u, " vsync"},        32'(vs_o[i]),  32'(exp_vs));
      check({where, "/", u, " video_active"}, 32'(va_o[i]),  32'(exp_va));
      check({where, "/", u, " line_start"},   32'(ls_o[i]),  32'(m[i].ls));
      check({where, "/", u, " frame_start"},  32'(fs_o[i]),  32'(m[i].fs));
   endtask

   task automatic tick(input logic e, input string where);
      en = e;
      @(posedge clk);
      model_step(0, e);
      model_step(1, e);
      cyc++;
      @(negedge clk);
      check_all(0, where);
      check_all(1, where);
      if (measure && fs_o[1]) begin
         if (last_fs >= 0) check("small frame period", 32'(cyc - last_fs), 32'd540);
         last_fs = cyc;
      end
   endtask

   initial begin
      geo[0] = '{ha: 800, hfp: 56, hs: 120, hbp: 64, va: 600, vfp: 37, vs: 6, vbp: 23, pol: 1'b1};
      geo[1] = '{ha: 16,  hfp: 4,  hs: 6,   hbp: 4,  va: 10,  vfp: 3,  vs: 2, vbp: 3,  pol: 1'b0};
      model_reset(0);
      model_reset(1);

      // Reset state.
      repeat (3) @(negedge clk);
      check_all(0, "reset");
      check_all(1, "reset");

      // First enabled edge after release lands on (0,0) with both strobes.
      rst_n = 1'b1;
      measure = 1'b1;
      tick(1'b1, "first");
      check("first frame_start big", 32'(fs_o[0]), 32'd1);
      check("first video_active big", 32'(va_o[0]), 32'd1);

      // Free run: three full lines on the big unit, several frames on the small one.
      for (int k = 0; k < 3 * 1040; k++) tick(1'b1, "run");
      measure = 1'b0;
      check("small frames seen", 32'(last_fs > 1000), 32'd1);

      // Enable gating just before hsync on the big unit.
      for (int k = 0; k < 2100 && m[0].h != 855; k++) tick(1'b1, "seek");
      for (int k = 0; k < 5; k++) tick(1'b0, "gate");
      check("gate hold h_count", 32'(h_cnt[0]), 32'd855);
      check("gate hold hsync", 32'(hs_o[0]), 32'd0);
      tick(1'b1, "resume");
      check("resume h_count", 32'(h_cnt[0]), 32'd856);
      check("resume hsync", 32'(hs_o[0]), 32'd1);

      // Randomized enable.
      for (int k = 0; k < 3000; k++) tick(1'($urandom_range(0, 3) != 0), "rand");

      // Mid-frame asynchronous reset, observed before the next edge.
      for (int k = 0; k < int'($urandom_range(100, 900)); k++) tick(1'b1, "pre_rst");
      #3;
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      check_all(0, "async_rst");
      check_all(1, "async_rst");
      repeat (2) @(negedge clk);
      check_all(0, "rst_hold");
      check_all(1, "rst_hold");
      rst_n = 1'b1;
      tick(1'b1, "restart");
      check("restart h_count", 32'(h_cnt[0]), 32'd0);
      check("restart frame_start", 32'(fs_o[1]), 32'd1);

      for (int k = 0; k < 1500; k++) tick(1'($urandom_range(0, 4) != 0), "rand2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
